// File: rtl/harmonic_magnitude_calc.sv
// harmonic_magnitude_calc
// Captures one frame of five complex harmonic coefficients, computes each
// squared magnitude re^2+im^2 through a single shared two-stage squaring
// pipeline, and reports the strongest harmonic plus a threshold flag.
// Frame timing: capture edge 0, issue on edges 1..5, last retire on edge 6,
// results and mags_valid_out registered on edge 7.

module harmonic_magnitude_calc #(
    parameter int unsigned NUM_HARM   = 5,
    parameter int unsigned COEFF_W    = 16,
    parameter logic [31:0] MAG_THRESH = 32'd4096
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  coeffs_valid_in,
    input  logic [NUM_HARM-1:0][2*COEFF_W-1:0]    coeffs_in,
    output logic                                  busy_out,
    output logic                                  mags_valid_out,
    output logic [NUM_HARM-1:0][2*COEFF_W-1:0]    harmonic_mags_out,
    output logic [2:0]                            dominant_idx_out,
    output logic                                  dominant_valid_out,
    output logic                                  overrun_out
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned MAG_W = 2 * COEFF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HARM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // FSM
    state_t                           r_state;
    state_t                           w_state_nxt;
    logic                             w_capture;
    logic                             w_issue;
    logic                             w_done;
    logic                             w_overrun_evt;
    logic                             w_busy_nxt;

    // Frame capture and issue pointer
    logic [NUM_HARM-1:0][MAG_W-1:0]   r_shadow;
    logic [IDX_W-1:0]                 r_idx;

    // Stage 1: individual squares
    logic [MAG_W-1:0]                 w_sel;
    logic signed [COEFF_W-1:0]        w_re;
    logic signed [COEFF_W-1:0]        w_im;
    logic signed [MAG_W-1:0]          w_re_x;
    logic signed [MAG_W-1:0]          w_im_x;
    logic signed [MAG_W-1:0]          w_rr;
    logic signed [MAG_W-1:0]          w_ii;
    logic                             r_s1_vld;
    logic [IDX_W-1:0]                 r_s1_idx;
    logic signed [MAG_W-1:0]          r_s1_rr;
    logic signed [MAG_W-1:0]          r_s1_ii;

    // Stage 2: magnitude, running maximum
    logic [MAG_W-1:0]                 w_sum;
    logic                             w_new_max;
    logic [NUM_HARM-1:0][MAG_W-1:0]   r_mag;
    logic [MAG_W-1:0]                 r_max;
    logic [IDX_W-1:0]                 r_max_idx;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (coeffs_valid_in) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_issue = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A pulse outside IDLE (including the DONE cycle) is dropped.
        w_overrun_evt = coeffs_valid_in && (r_state != S_IDLE);
        // Busy also covers the result cycle that follows DONE.
        w_busy_nxt    = (w_state_nxt != S_IDLE) || w_done;
    end

    // Shadow capture and issue pointer
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_shadow <= '0;
            r_idx    <= '0;
        end else if (w_capture) begin
            r_shadow <= coeffs_in;
            r_idx    <= '0;
        end else if (w_issue) begin
            r_idx    <= r_idx + IDX_W'(1);
        end
    end

    // Operand selection and squaring
    always_comb begin
        w_sel  = r_shadow[r_idx];
        w_re   = signed'(w_sel[MAG_W-1:COEFF_W]);
        w_im   = signed'(w_sel[COEFF_W-1:0]);
        w_re_x = MAG_W'(w_re);
        w_im_x = MAG_W'(w_im);
        w_rr   = w_re_x * w_re_x;
        w_ii   = w_im_x * w_im_x;
    end

    // Stage 1 pipeline register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_vld <= 1'b0;
            r_s1_idx <= '0;
            r_s1_rr  <= '0;
            r_s1_ii  <= '0;
        end else begin
            r_s1_vld <= w_issue;
            if (w_issue) begin
                r_s1_idx <= r_idx;
                r_s1_rr  <= w_rr;
                r_s1_ii  <= w_ii;
            end
        end
    end

    // Both squares are non-negative and at most 2^30, so the sum fits unsigned.
    always_comb begin
        w_sum     = $unsigned(r_s1_rr) + $unsigned(r_s1_ii);
        w_new_max = (r_s1_idx == '0) || (w_sum > r_max);
    end

    // Stage 2: store magnitude, track strict-greater maximum (ties keep lower index)
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mag     <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (r_s1_vld) begin
            r_mag[r_s1_idx] <= w_sum;
            if (w_new_max) begin
                r_max     <= w_sum;
                r_max_idx <= r_s1_idx;
            end
        end
    end

    // Result registers, updated only at DONE and held in between
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mags_valid_out     <= 1'b0;
            harmonic_mags_out  <= '0;
            dominant_idx_out   <= '0;
            dominant_valid_out <= 1'b0;
        end else begin
            mags_valid_out <= w_done;
            if (w_done) begin
                harmonic_mags_out  <= r_mag;
                dominant_idx_out   <= r_max_idx;
                dominant_valid_out <= (r_max >= MAG_THRESH);
            end
        end
    end

    // Busy flag and sticky overrun
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            busy_out <= w_busy_nxt;
            if (w_overrun_evt) begin
                overrun_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_harmonic_magnitude_calc.sv
// Self-checking bench for harmonic_magnitude_calc: directed table vectors,
// hand-written overrun/reset sequences, and random back-to-back frames
// compared against an arithmetic reference model.

module tb_harmonic_magnitude_calc;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              coeffs_valid_in = 1'b0;
    logic [4:0][31:0]  coeffs_in = '0;
    logic              busy_out;
    logic              mags_valid_out;
    logic [4:0][31:0]  harmonic_mags_out;
    logic [2:0]        dominant_idx_out;
    logic              dominant_valid_out;
    logic              overrun_out;

    int checks = 0;
    int errors = 0;

    harmonic_magnitude_calc dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .coeffs_valid_in    (coeffs_valid_in),
        .coeffs_in          (coeffs_in),
        .busy_out           (busy_out),
        .mags_valid_out     (mags_valid_out),
        .harmonic_mags_out  (harmonic_mags_out),
        .dominant_idx_out   (dominant_idx_out),
        .dominant_valid_out (dominant_valid_out),
        .overrun_out        (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0][31:0] coeffs;
        logic [4:0][31:0] exp_mags;
        logic [2:0]       exp_idx;
        logic             exp_dv;
    } vec_t;

    vec_t vecs[5];

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_c(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = 16'(re);
        i = 16'(im);
        return {r, i};
    endfunction

    // Reference: squared magnitude by plain integer arithmetic, argmax with first-wins ties
    task automatic model(input logic [4:0][31:0] c, output logic [4:0][31:0] m,
                         output logic [2:0] idx, output logic dv);
        longint best;
        longint re;
        longint im;
        longint mk;
        best = -1;
        idx  = 3'd0;
        for (int k = 0; k < 5; k++) begin
            re = longint'($signed(c[k][31:16]));
            im = longint'($signed(c[k][15:0]));
            mk = re * re + im * im;
            m[k] = 32'(mk);
            if (mk > best) begin
                best = mk;
                idx  = 3'(k);
            end
        end
        dv = (best >= 64'd4096);
    endtask

    task automatic scramble_inputs;
        for (int k = 0; k < 5; k++) coeffs_in[k] = $urandom();
    endtask

    // Present a one-cycle valid pulse; inputs are scrambled afterwards
    task automatic send(input logic [4:0][31:0] c);
        coeffs_valid_in = 1'b1;
        coeffs_in       = c;
        tick();
        coeffs_valid_in = 1'b0;
        scramble_inputs();
    endtask

    // Wait (bounded) for mags_valid_out; lat counts edges after the capture edge
    task automatic wait_pulse(output int lat, output bit stable);
        logic [4:0][31:0] snap;
        snap   = harmonic_mags_out;
        stable = 1'b1;
        lat    = 0;
        while (!mags_valid_out && lat < 30) begin
            tick();
            lat++;
            if (!mags_valid_out && harmonic_mags_out !== snap) stable = 1'b0;
        end
    endtask

    task automatic check_result(input string tag, input logic [4:0][31:0] m,
                                input logic [2:0] idx, input logic dv);
        for (int k = 0; k < 5; k++)
            chk($sformatf("%s mag%0d", tag, k), 64'(harmonic_mags_out[k]), 64'(m[k]));
        chk({tag, " idx"}, 64'(dominant_idx_out), 64'(idx));
        chk({tag, " dv"},  64'(dominant_valid_out), 64'(dv));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " busy"},    64'(busy_out), 64'd0);
        chk({tag, " mvalid"},  64'(mags_valid_out), 64'd0);
        chk({tag, " mags"},    64'(harmonic_mags_out == '0), 64'd1);
        chk({tag, " idx"},     64'(dominant_idx_out), 64'd0);
        chk({tag, " dv"},      64'(dominant_valid_out), 64'd0);
        chk({tag, " overrun"}, 64'(overrun_out), 64'd0);
    endtask

    task automatic full_frame(input string tag, input logic [4:0][31:0] c,
                              input logic [4:0][31:0] m, input logic [2:0] idx, input logic dv);
        int lat;
        bit stable;
        send(c);
        chk({tag, " busy_at_capture"}, 64'(busy_out), 64'd1);
        wait_pulse(lat, stable);
        chk({tag, " latency"}, 64'(lat), 64'd7);
        chk({tag, " busy_at_pulse"}, 64'(busy_out), 64'd1);
        check_result(tag, m, idx, dv);
        tick();
        chk({tag, " pulse_single"}, 64'(mags_valid_out), 64'd0);
        chk({tag, " busy_after"}, 64'(busy_out), 64'd0);
    endtask

    function automatic logic [31:0] rand_comp16x2();
        logic [15:0] r;
        logic [15:0] i;
        r = 16'($urandom());
        i = 16'($urandom());
        if ($urandom_range(0, 7) == 0) r = 16'h8000;
        if ($urandom_range(0, 7) == 0) i = 16'h8000;
        if ($urandom_range(0, 3) == 0) r = 16'($signed(r) >>> 8);
        return {r, i};
    endfunction

    initial begin : main
        logic [4:0][31:0] ca;
        logic [4:0][31:0] cb;
        logic [4:0][31:0] m;
        logic [2:0]       idx;
        logic             dv;
        logic [4:0][31:0] got_m;
        int               pulses;
        int               lat;
        bit               stable;

        // Directed vectors with hand-derived expectations
        for (int v = 0; v < 5; v++) begin
            vecs[v].coeffs   = '0;
            vecs[v].exp_mags = '0;
        end
        for (int k = 0; k < 5; k++) begin
            vecs[0].coeffs[k]   = pack_c(3, 4);
            vecs[0].exp_mags[k] = 32'd25;
        end
        vecs[0].exp_idx = 3'd0; vecs[0].exp_dv = 1'b0;

        vecs[1].coeffs[2]   = pack_c(-32768, -32768);
        vecs[1].exp_mags[2] = 32'h8000_0000;
        vecs[1].exp_idx = 3'd2; vecs[1].exp_dv = 1'b1;

        for (int k = 0; k < 5; k++) begin
            vecs[2].coeffs[k]   = pack_c(10, 10);
            vecs[2].exp_mags[k] = 32'd200;
        end
        vecs[2].coeffs[1] = pack_c(100, 0); vecs[2].exp_mags[1] = 32'd10000;
        vecs[2].coeffs[3] = pack_c(100, 0); vecs[2].exp_mags[3] = 32'd10000;
        vecs[2].exp_idx = 3'd1; vecs[2].exp_dv = 1'b1;

        vecs[3].coeffs[3]   = pack_c(64, 0);
        vecs[3].exp_mags[3] = 32'd4096;
        vecs[3].coeffs[1]   = pack_c(-1, -63);
        vecs[3].exp_mags[1] = 32'd3970;
        vecs[3].exp_idx = 3'd3; vecs[3].exp_dv = 1'b1;

        vecs[4].coeffs[4]   = pack_c(0, -63);
        vecs[4].exp_mags[4] = 32'd3969;
        vecs[4].coeffs[0]   = pack_c(-5, 12);
        vecs[4].exp_mags[0] = 32'd169;
        vecs[4].exp_idx = 3'd4; vecs[4].exp_dv = 1'b0;

        // Reset state
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
        check_cleared("reset");

        for (int v = 0; v < 5; v++)
            full_frame($sformatf("vec%0d", v), vecs[v].coeffs, vecs[v].exp_mags,
                       vecs[v].exp_idx, vecs[v].exp_dv);

        // Second pulse three cycles after capture is dropped and flags overrun
        ca = vecs[2].coeffs;
        cb = vecs[1].coeffs;
        send(ca);
        tick(); tick();
        coeffs_valid_in = 1'b1;
        coeffs_in       = cb;
        tick();
        coeffs_valid_in = 1'b0;
        pulses = 0;
        got_m  = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mags_valid_out) begin
                pulses++;
                got_m = harmonic_mags_out;
            end
        end
        chk("ovr pulses", 64'(pulses), 64'd1);
        chk("ovr frame_kept", 64'(got_m == vecs[2].exp_mags), 64'd1);
        chk("ovr flag", 64'(overrun_out), 64'd1);
        full_frame("ovr_next", vecs[0].coeffs, vecs[0].exp_mags, 3'd0, 1'b0);
        chk("ovr sticky", 64'(overrun_out), 64'd1);

        // Pulse during the DONE cycle is also dropped
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        chk("rst clears overrun", 64'(overrun_out), 64'd0);
        send(vecs[3].coeffs);
        for (int i = 0; i < 6; i++) tick();
        coeffs_valid_in = 1'b1;
        coeffs_in       = vecs[1].coeffs;
        tick();
        coeffs_valid_in = 1'b0;
        chk("done_drop pulse", 64'(mags_valid_out), 64'd1);
        check_result("done_drop", vecs[3].exp_mags, 3'd3, 1'b1);
        chk("done_drop overrun", 64'(overrun_out), 64'd1);
        tick();
        chk("done_drop busy_after", 64'(busy_out), 64'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mags_valid_out) pulses++;
        end
        chk("done_drop no_second", 64'(pulses), 64'd0);

        // Reset four cycles after capture aborts the frame
        send(vecs[1].coeffs);
        for (int i = 0; i < 4; i++) tick();
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        check_cleared("abort");
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mags_valid_out) pulses++;
        end
        chk("abort no_pulse", 64'(pulses), 64'd0);
        full_frame("post_abort", vecs[1].coeffs, vecs[1].exp_mags, 3'd2, 1'b1);

        // Random frames back-to-back at maximum rate
        for (int k = 0; k < 5; k++) ca[k] = rand_comp16x2();
        send(ca);
        for (int f = 1; f <= 30; f++) begin
            wait_pulse(lat, stable);
            chk($sformatf("rnd%0d latency", f), 64'(lat), 64'd7);
            chk($sformatf("rnd%0d held", f), 64'(stable), 64'd1);
            chk($sformatf("rnd%0d busy", f), 64'(busy_out), 64'd1);
            model(ca, m, idx, dv);
            check_result($sformatf("rnd%0d", f), m, idx, dv);
            if (f < 30) begin
                for (int k = 0; k < 5; k++) ca[k] = rand_comp16x2();
                if (f % 7 == 0) begin
                    ca[1] = ca[0];
                    ca[4] = ca[0];
                end
                send(ca);
            end
        end
        tick();
        chk("rnd no_overrun", 64'(overrun_out), 64'd0);
        chk("rnd idle", 64'(busy_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
